// File: rtl/protocol_state_machine.sv
`default_nettype none
// ============================================================================
//  Module   : protocol_state_machine
//  Purpose  : Slave-side four-phase req/ack handshake controller with a
//             single data register. Advertises ready while idle, captures
//             data_in on an accepted request, holds ack until req drops,
//             then spends one recovery cycle before becoming ready again.
//  Ports    : clk      - system clock, rising edge active
//             rst      - asynchronous active-high reset
//             req      - level-sensitive request from the master
//             data_in  - request payload, sampled on the accepting edge
//             ack      - acknowledge, high while the transfer is held
//             ready    - block can accept a new request
//             data_out - last captured payload
//  Revision : 1.0 - initial release
// ============================================================================
module protocol_state_machine #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ack,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ACK     = 2'b01,
    S_RELEASE = 2'b10
  } state_t;

  state_t                r_state;
  logic                  r_ack;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_data_out;

  // Outputs are computed alongside the next state so every output is a flop
  // and no input reaches an output without passing through a register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ack      <= 1'b0;
      r_ready    <= 1'b1;
      r_data_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_state    <= S_ACK;
            r_ack      <= 1'b1;
            r_ready    <= 1'b0;
            r_data_out <= data_in;
          end else begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        S_ACK: begin
          // Payload is frozen here; only the acceptance-edge value is kept.
          if (!req) begin
            r_state <= S_RELEASE;
            r_ack   <= 1'b0;
            r_ready <= 1'b0;
          end else begin
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            r_ready <= 1'b0;
          end
        end
        S_RELEASE: begin
          // One unconditional recovery cycle; req is ignored.
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          // Unused encoding recovers to IDLE.
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign ready    = r_ready;
  assign data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_protocol_state_machine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_protocol_state_machine
//  Purpose  : Directed self-checking bench for protocol_state_machine.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_protocol_state_machine;

  localparam int DATA_WIDTH = 8;

  logic                  clk;
  logic                  rst;
  logic                  req;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ack;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data_out;

  int n_checks = 0;
  int n_pass   = 0;

  protocol_state_machine #(.DATA_WIDTH(DATA_WIDTH)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .ready    (ready),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_out(input string tag, input logic e_ack, input logic e_ready,
                           input logic [DATA_WIDTH-1:0] e_data);
    check({tag, ".ack"},   {31'd0, ack},   {31'd0, e_ack});
    check({tag, ".ready"}, {31'd0, ready}, {31'd0, e_ready});
    check({tag, ".data"},  {24'd0, data_out}, {24'd0, e_data});
  endtask

  // Advance one active edge and return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Complete four-phase transfer: accept, hold req for 'hold' extra cycles,
  // drop req, pass through RELEASE and back to IDLE.
  task automatic do_xfer(input string tag, input logic [DATA_WIDTH-1:0] d, input int hold);
    data_in = d;
    req     = 1'b1;
    step();
    check_out({tag, ".accept"}, 1'b1, 1'b0, d);
    for (int i = 0; i < hold; i++) begin
      step();
      check_out({tag, ".hold"}, 1'b1, 1'b0, d);
    end
    req = 1'b0;
    step();
    check_out({tag, ".release"}, 1'b0, 1'b0, d);
    step();
    check_out({tag, ".idle"}, 1'b0, 1'b1, d);
  endtask

  initial begin
    rst     = 1'b1;
    req     = 1'b0;
    data_in = '0;

    // 1: reset then idle
    @(negedge clk);
    check_out("rst0", 1'b0, 1'b1, 8'h00);
    step();
    check_out("rst1", 1'b0, 1'b1, 8'h00);
    rst = 1'b0;
    step();
    check_out("idle0", 1'b0, 1'b1, 8'h00);
    step();
    check_out("idle1", 1'b0, 1'b1, 8'h00);

    // 2: single transfer, req held two extra cycles
    do_xfer("x_a5", 8'hA5, 2);

    // 3: sequential transfers, with an idle gap to confirm data holds
    do_xfer("x_3c", 8'h3C, 0);
    step();
    check_out("gap_3c", 1'b0, 1'b1, 8'h3C);
    do_xfer("x_ff", 8'hFF, 0);
    step();
    check_out("gap_ff", 1'b0, 1'b1, 8'hFF);
    do_xfer("x_00", 8'h00, 0);

    // 4: data_in changes while ack is high
    data_in = 8'h55;
    req     = 1'b1;
    step();
    check_out("d55.accept", 1'b1, 1'b0, 8'h55);
    data_in = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("d55.hold", 1'b1, 1'b0, 8'h55);
    end
    req = 1'b0;
    step();
    check_out("d55.release", 1'b0, 1'b0, 8'h55);
    step();
    check_out("d55.idle", 1'b0, 1'b1, 8'h55);

    // 5: req re-raised during RELEASE is accepted at the first IDLE edge
    data_in = 8'h12;
    req     = 1'b1;
    step();
    check_out("r12.accept", 1'b1, 1'b0, 8'h12);
    step();
    check_out("r12.hold", 1'b1, 1'b0, 8'h12);
    req = 1'b0;
    step();
    check_out("r12.release", 1'b0, 1'b0, 8'h12);
    req     = 1'b1;
    data_in = 8'h34;
    step();
    check_out("r12.idle", 1'b0, 1'b1, 8'h12);
    step();
    check_out("r34.accept", 1'b1, 1'b0, 8'h34);
    req = 1'b0;
    step();
    check_out("r34.release", 1'b0, 1'b0, 8'h34);
    step();
    check_out("r34.idle", 1'b0, 1'b1, 8'h34);

    // 6: asynchronous reset mid-transfer, no clock edge in between
    data_in = 8'hA5;
    req     = 1'b1;
    step();
    check_out("m_a5.accept", 1'b1, 1'b0, 8'hA5);
    #2 rst = 1'b1;
    #1 check_out("async_rst", 1'b0, 1'b1, 8'h00);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    check_out("post_rst", 1'b0, 1'b1, 8'h00);
    do_xfer("x_a5b", 8'hA5, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
